// File: rtl/fft_pkg.sv
// -----------------------------------------------------------------------------
// fft_pkg
// Shared definitions for the FFT result streaming path. It holds the default
// frame geometry, the stream FSM state type and the index bit-reversal helper
// that the reorder build uses.
// No ports (package).
// -----------------------------------------------------------------------------
package fft_pkg;

    localparam int FFT_N     = 64;
    localparam int FFT_W     = 16;
    localparam int FFT_LOG2N = 6;

    // The streamer has two states. IDLE means no frame is held. STREAM means
    // a frame is held and is presented to downstream.
    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } streamState_e;

    // Mirrors the index bits. The FFT produces its results in bit-reversed
    // order, so reading buffer[bitrev(k)] yields natural order.
    function automatic logic [FFT_LOG2N-1:0] bitrev(input logic [FFT_LOG2N-1:0] v);
        logic [FFT_LOG2N-1:0] r;
        for (int i = 0; i < FFT_LOG2N; i++) begin
            r[i] = v[FFT_LOG2N-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_sample_mux.sv
// -----------------------------------------------------------------------------
// fft_sample_mux
// This is a combinational N:1 selector. It picks one W-bit component out of a
// flattened frame bus.
// Ports:
//   flatIn  [N*W-1:0] in  : frame bus, sample k at bits [k*W +: W]
//   sel     [log2N-1:0] in: sample index to select
//   sample  [W-1:0]   out : selected component, passed bit-exact
// -----------------------------------------------------------------------------
module fft_sample_mux
    import fft_pkg::*;
#(
    parameter int N    = FFT_N,
    parameter int W    = FFT_W,
    parameter int SELW = $clog2(N)
) (
    input  logic [N*W-1:0]  flatIn,
    input  logic [SELW-1:0] sel,
    output logic [W-1:0]    sample
);

    logic [W-1:0] lane [N];

    generate
        for (genvar gi = 0; gi < N; gi++) begin : gLane
            assign lane[gi] = flatIn[gi*W +: W];
        end
    endgenerate

    assign sample = lane[sel];

endmodule

// File: rtl/fft_result_streamer.sv
// -----------------------------------------------------------------------------
// fft_result_streamer
// This block captures one complete FFT result frame when done pulses. It then
// streams the frame one complex sample per cycle over a valid/ready interface,
// and it reports the natural frequency index with each sample.
//
// Build option: when FFT_BITREV_REORDER_EN is defined, the buffer is read at
// bitrev(idx). This converts bit-reversed FFT output into natural order.
// outIdx is always the natural index.
//
// Ports:
//   clk            in  : clock, rising edge
//   rst            in  : asynchronous active-low reset
//   done           in  : one-cycle pulse, inRe/inIm valid in that cycle
//   inRe, inIm     in  : flattened frame, sample k at [k*W +: W]
//   outReady       in  : downstream accepts the current sample
//   outValid       out : outRe/outIm/outIdx/outLast are valid
//   outRe, outIm   out : current sample components
//   outIdx         out : natural index of the current sample
//   outLast        out : current sample is index N-1
//   busy           out : a frame is held / being streamed
//   overrun        out : sticky, a done pulse was dropped while streaming
// -----------------------------------------------------------------------------
module fft_result_streamer
    import fft_pkg::*;
#(
    parameter int N = FFT_N,
    parameter int W = FFT_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 done,
    input  logic [N*W-1:0]       inRe,
    input  logic [N*W-1:0]       inIm,
    input  logic                 outReady,
    output logic                 outValid,
    output logic [W-1:0]         outRe,
    output logic [W-1:0]         outIm,
    output logic [$clog2(N)-1:0] outIdx,
    output logic                 outLast,
    output logic                 busy,
    output logic                 overrun
);

    localparam int IW = $clog2(N);
    localparam logic [IW-1:0] IDX_LAST = IW'(N - 1);
    localparam logic [IW-1:0] IDX_ONE  = IW'(1);

    streamState_e  state;
    streamState_e  stateNext;
    logic [IW-1:0] idx;
    logic [IW-1:0] idxNext;
    logic [IW-1:0] rdIdx;
    logic          capture;
    logic          overrunSet;
    logic          streaming;
    logic          atLast;
    logic          xfer;
    logic [N*W-1:0] bufRe;
    logic [N*W-1:0] bufIm;
    logic [W-1:0]  muxRe;
    logic [W-1:0]  muxIm;

    assign streaming = (state == STREAM);
    assign atLast    = (idx == IDX_LAST);
    assign xfer      = streaming && outReady;

    // State, index and sticky flag. These are the only reset registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            idx     <= '0;
            overrun <= 1'b0;
        end else begin
            state <= stateNext;
            idx   <= idxNext;
            if (overrunSet) begin
                overrun <= 1'b1;
            end
        end
    end

    // The frame buffer has no reset. After reset it is only read once a new
    // done has overwritten it.
    always_ff @(posedge clk) begin
        if (capture) begin
            bufRe <= inRe;
            bufIm <= inIm;
        end
    end

    always_comb begin
        stateNext  = state;
        idxNext    = idx;
        capture    = 1'b0;
        overrunSet = 1'b0;
        case (state)
            IDLE: begin
                if (done) begin
                    capture   = 1'b1;
                    idxNext   = '0;
                    stateNext = STREAM;
                end
            end
            STREAM: begin
                if (xfer && atLast) begin
                    // A done that lands exactly on the final transfer chains the
                    // next frame without a bubble. Otherwise the FSM goes idle.
                    idxNext = '0;
                    if (done) begin
                        capture = 1'b1;
                    end else begin
                        stateNext = IDLE;
                    end
                end else begin
                    if (xfer) begin
                        idxNext = idx + IDX_ONE;
                    end
                    // The held frame is still in use, so the new one is lost.
                    if (done) begin
                        overrunSet = 1'b1;
                    end
                end
            end
            default: begin
                stateNext = IDLE;
                idxNext   = '0;
            end
        endcase
    end

`ifdef FFT_BITREV_REORDER_EN
    assign rdIdx = bitrev(idx);
`else
    assign rdIdx = idx;
`endif

    fft_sample_mux #(.N(N), .W(W), .SELW(IW)) uMuxRe (
        .flatIn (bufRe),
        .sel    (rdIdx),
        .sample (muxRe)
    );

    fft_sample_mux #(.N(N), .W(W), .SELW(IW)) uMuxIm (
        .flatIn (bufIm),
        .sel    (rdIdx),
        .sample (muxIm)
    );

    // Data is gated by state. The unreset buffer is never visible while idle
    // or in reset, and the outputs hold because idx and the buffer hold.
    assign outValid = streaming;
    assign busy     = streaming;
    assign outLast  = streaming && atLast;
    assign outIdx   = idx;
    assign outRe    = streaming ? muxRe : '0;
    assign outIm    = streaming ? muxIm : '0;

endmodule

// File: tb/tb_fft_result_streamer.sv
module tb_fft_result_streamer;

    localparam int N  = 64;
    localparam int W  = 16;
    localparam int IW = 6;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           done = 1'b0;
    logic           outReady = 1'b0;
    logic [N*W-1:0] inRe = '0;
    logic [N*W-1:0] inIm = '0;
    logic           outValid;
    logic [W-1:0]   outRe;
    logic [W-1:0]   outIm;
    logic [IW-1:0]  outIdx;
    logic           outLast;
    logic           busy;
    logic           overrun;

    int total = 0;
    int bad   = 0;

    logic [W-1:0] fRe [N];
    logic [W-1:0] fIm [N];
    logic [W-1:0] nRe [N];
    logic [W-1:0] nIm [N];

    fft_result_streamer #(.N(N), .W(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .done     (done),
        .inRe     (inRe),
        .inIm     (inIm),
        .outReady (outReady),
        .outValid (outValid),
        .outRe    (outRe),
        .outIm    (outIm),
        .outIdx   (outIdx),
        .outLast  (outLast),
        .busy     (busy),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    function automatic int ord(input int k);
        int r;
        r = k;
`ifdef FFT_BITREV_REORDER_EN
        r = 0;
        for (int b = 0; b < IW; b++) begin
            if (((k >> b) & 1) != 0) r = r | (1 << (IW - 1 - b));
        end
`endif
        return r;
    endfunction

    task automatic fill(input int kind);
        for (int k = 0; k < N; k++) begin
            case (kind)
                0:       begin nRe[k] = (k < 32) ? W'(4) : W'(0); nIm[k] = '0; end
                1:       begin nRe[k] = W'(k); nIm[k] = W'(-k); end
                default: begin nRe[k] = W'($urandom); nIm[k] = W'($urandom); end
            endcase
            inRe[k*W +: W] = nRe[k];
            inIm[k*W +: W] = nIm[k];
        end
    endtask

    task automatic accept();
        for (int k = 0; k < N; k++) begin
            fRe[k] = nRe[k];
            fIm[k] = nIm[k];
        end
    endtask

    task automatic scramble();
        for (int k = 0; k < N; k++) begin
            inRe[k*W +: W] = W'($urandom);
            inIm[k*W +: W] = W'($urandom);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        total++;
        if ({outValid, busy, overrun, outLast, outIdx, outRe, outIm} !== '0) begin
            bad++;
            $display("FAIL reset_state got v=%b b=%b o=%b l=%b i=%0d re=%h im=%h want all 0",
                     outValid, busy, overrun, outLast, outIdx, outRe, outIm);
        end
        rst = 1'b1;
        @(negedge clk);
        total++;
        if ({outValid, busy, overrun} !== 3'b000) begin
            bad++;
            $display("FAIL reset_release got v=%b b=%b o=%b want 000", outValid, busy, overrun);
        end
        $display("test_reset done");
    endtask

    task automatic test_pattern();
        fill(0);
        outReady = 1'b1;
        @(negedge clk);
        total++;
        if (outValid !== 1'b0) begin
            bad++;
            $display("FAIL pattern_pre_done got v=%b want 0", outValid);
        end
        done = 1'b1;
        accept();
        @(negedge clk);
        done = 1'b0;
        scramble();
        for (int k = 0; k < N; k++) begin
            total++;
            if ({outValid, busy, outLast, outIdx, outRe, outIm} !==
                {1'b1, 1'b1, (k == N-1), IW'(k), fRe[ord(k)], fIm[ord(k)]}) begin
                bad++;
                $display("FAIL pattern k=%0d got v=%b b=%b l=%b i=%0d re=%h im=%h want re=%h im=%h",
                         k, outValid, busy, outLast, outIdx, outRe, outIm, fRe[ord(k)], fIm[ord(k)]);
            end
            @(negedge clk);
        end
        total++;
        if ({outValid, busy, outLast} !== 3'b000) begin
            bad++;
            $display("FAIL pattern_end got v=%b b=%b l=%b want 000", outValid, busy, outLast);
        end
        $display("test_pattern done");
    endtask

    task automatic test_stall();
        bit pat [4];
        int cnt;
        int cyc;
        bit stalled;
        logic [W-1:0]  pRe;
        logic [W-1:0]  pIm;
        logic [IW-1:0] pIdx;
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
        cnt = 0; cyc = 0; stalled = 1'b0;
        pRe = '0; pIm = '0; pIdx = '0;
        fill(1);
        outReady = 1'b0;
        done = 1'b1;
        accept();
        @(negedge clk);
        done = 1'b0;
        scramble();
        while (cnt < N && cyc < 1000) begin
            total++;
            if ({outValid, outLast, outIdx, outRe, outIm} !==
                {1'b1, (cnt == N-1), IW'(cnt), fRe[ord(cnt)], fIm[ord(cnt)]}) begin
                bad++;
                $display("FAIL stall_data n=%0d got v=%b l=%b i=%0d re=%h im=%h want re=%h im=%h",
                         cnt, outValid, outLast, outIdx, outRe, outIm, fRe[ord(cnt)], fIm[ord(cnt)]);
            end
            if (stalled) begin
                total++;
                if ({outRe, outIm, outIdx} !== {pRe, pIm, pIdx}) begin
                    bad++;
                    $display("FAIL stall_hold got i=%0d re=%h im=%h want i=%0d re=%h im=%h",
                             outIdx, outRe, outIm, pIdx, pRe, pIm);
                end
            end
            outReady = pat[cyc % 4];
            pRe = outRe; pIm = outIm; pIdx = outIdx;
            stalled = !outReady;
            if (outValid && outReady) cnt++;
            cyc++;
            @(negedge clk);
        end
        total++;
        if (cnt !== N) begin
            bad++;
            $display("FAIL stall_count got %0d want %0d", cnt, N);
        end
        total++;
        if (outValid !== 1'b0) begin
            bad++;
            $display("FAIL stall_end got v=%b want 0", outValid);
        end
        $display("test_stall done transfers=%0d cycles=%0d", cnt, cyc);
    endtask

    task automatic test_overrun();
        fill(2);
        outReady = 1'b1;
        done = 1'b1;
        accept();
        @(negedge clk);
        done = 1'b0;
        scramble();
        for (int k = 0; k < N; k++) begin
            total++;
            if ({outValid, outIdx, outRe, outIm} !== {1'b1, IW'(k), fRe[ord(k)], fIm[ord(k)]}) begin
                bad++;
                $display("FAIL overrun_data k=%0d got v=%b i=%0d re=%h im=%h want re=%h im=%h",
                         k, outValid, outIdx, outRe, outIm, fRe[ord(k)], fIm[ord(k)]);
            end
            if (k == 10) begin
                total++;
                if (overrun !== 1'b0) begin
                    bad++;
                    $display("FAIL overrun_before got %b want 0", overrun);
                end
                done = 1'b1;
                fill(2);
            end else if (k == 11) begin
                done = 1'b0;
                scramble();
                total++;
                if (overrun !== 1'b1) begin
                    bad++;
                    $display("FAIL overrun_set got %b want 1", overrun);
                end
            end
            @(negedge clk);
        end
        total++;
        if ({outValid, overrun} !== 2'b01) begin
            bad++;
            $display("FAIL overrun_end got v=%b o=%b want v=0 o=1", outValid, overrun);
        end
        rst = 1'b0;
        #1;
        total++;
        if (overrun !== 1'b0) begin
            bad++;
            $display("FAIL overrun_clear got %b want 0", overrun);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        $display("test_overrun done");
    endtask

    task automatic test_back_to_back();
        int cnt;
        int cyc;
        fill(2);
        outReady = 1'b1;
        done = 1'b1;
        accept();
        @(negedge clk);
        done = 1'b0;
        scramble();
        for (int k = 0; k < N; k++) begin
            total++;
            if ({outValid, outIdx, outRe, outIm} !== {1'b1, IW'(k), fRe[ord(k)], fIm[ord(k)]}) begin
                bad++;
                $display("FAIL b2b_first k=%0d got v=%b i=%0d re=%h im=%h want re=%h im=%h",
                         k, outValid, outIdx, outRe, outIm, fRe[ord(k)], fIm[ord(k)]);
            end
            if (k == N-1) begin
                done = 1'b1;
                fill(2);
            end
            @(negedge clk);
        end
        done = 1'b0;
        accept();
        scramble();
        cnt = 0; cyc = 0;
        while (cnt < N && cyc < 1000) begin
            total++;
            if ({outValid, overrun, outLast, outIdx, outRe, outIm} !==
                {1'b1, 1'b0, (cnt == N-1), IW'(cnt), fRe[ord(cnt)], fIm[ord(cnt)]}) begin
                bad++;
                $display("FAIL b2b_second n=%0d got v=%b o=%b l=%b i=%0d re=%h im=%h want re=%h im=%h",
                         cnt, outValid, overrun, outLast, outIdx, outRe, outIm, fRe[ord(cnt)], fIm[ord(cnt)]);
            end
            outReady = ($urandom_range(0, 1) == 1);
            if (outValid && outReady) cnt++;
            cyc++;
            @(negedge clk);
        end
        total++;
        if ({cnt == N, outValid, overrun} !== 3'b100) begin
            bad++;
            $display("FAIL b2b_end got n=%0d v=%b o=%b want n=%0d v=0 o=0", cnt, outValid, overrun, N);
        end
        $display("test_back_to_back done cycles=%0d", cyc);
    endtask

    task automatic test_reset_midframe();
        int cyc;
        fill(2);
        outReady = 1'b1;
        done = 1'b1;
        accept();
        @(negedge clk);
        done = 1'b0;
        scramble();
        for (int k = 0; k <= 20; k++) begin
            total++;
            if ({outValid, outIdx, outRe, outIm} !== {1'b1, IW'(k), fRe[ord(k)], fIm[ord(k)]}) begin
                bad++;
                $display("FAIL rstmid_data k=%0d got v=%b i=%0d re=%h im=%h want re=%h im=%h",
                         k, outValid, outIdx, outRe, outIm, fRe[ord(k)], fIm[ord(k)]);
            end
            if (k == 5) done = 1'b1;
            if (k == 6) done = 1'b0;
            if (k == 20) begin
                rst = 1'b0;
                #1;
                total++;
                if ({outValid, busy, overrun, outLast, outIdx, outRe, outIm} !== '0) begin
                    bad++;
                    $display("FAIL rstmid_async got v=%b b=%b o=%b l=%b i=%0d re=%h im=%h want all 0",
                             outValid, busy, overrun, outLast, outIdx, outRe, outIm);
                end
            end else begin
                @(negedge clk);
            end
        end
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            total++;
            if ({outValid, busy} !== 2'b00) begin
                bad++;
                $display("FAIL rstmid_quiet c=%0d got v=%b b=%b want 00", c, outValid, busy);
            end
        end
        fill(2);
        done = 1'b1;
        accept();
        @(negedge clk);
        done = 1'b0;
        scramble();
        total++;
        if ({outValid, outIdx, outRe, outIm} !== {1'b1, IW'(0), fRe[ord(0)], fIm[ord(0)]}) begin
            bad++;
            $display("FAIL rstmid_restart got v=%b i=%0d re=%h im=%h want v=1 i=0 re=%h im=%h",
                     outValid, outIdx, outRe, outIm, fRe[ord(0)], fIm[ord(0)]);
        end
        cyc = 0;
        while (outValid && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        total++;
        if (outValid !== 1'b0) begin
            bad++;
            $display("FAIL rstmid_drain got v=%b want 0", outValid);
        end
        $display("test_reset_midframe done");
    endtask

    initial begin
        test_reset();
        test_pattern();
        test_stall();
        test_overrun();
        test_back_to_back();
        test_reset_midframe();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fft_result_streamer.md
FFT_RESULT_STREAMER -- requirements
Module: fft_result_streamer

Interface
REQ-001 Parameter N, default 64, number of complex samples per frame.
REQ-002 Parameter W, default 16, bits per real or imaginary component.
REQ-003 Port clk, input, 1, single clock; all state changes on the rising edge.
REQ-004 Port rst, input, 1, reset; asynchronous and active-low.
REQ-005 Port done, input, 1, one-cycle pulse from fft; the result buses are valid in that cycle.
REQ-006 Port inRe, input, N*W, flattened real results; sample k occupies bits [k*W +: W].
REQ-007 Port inIm, input, N*W, flattened imaginary results; same packing as inRe.
REQ-008 Port outReady, input, 1, downstream accepts the current sample.
REQ-009 Port outValid, output, 1, outRe/outIm/outIdx/outLast are valid.
REQ-010 Port outRe and outIm, output, W each, current sample, two's complement.
REQ-011 Port outIdx, output, log2(N), natural frequency index of the current sample.
REQ-012 Port outLast, output, 1, high with the sample where outIdx == N-1.
REQ-013 Port busy, output, 1, high while a frame is held or being streamed.
REQ-014 Port overrun, output, 1, sticky; set when a frame is dropped.

Function
REQ-015 FSM states IDLE and STREAM only.
REQ-016 In IDLE with done=1, the block shall register inRe/inIm into an internal frame buffer, set idx=0, and enter STREAM on the same edge.
REQ-017 In STREAM, outValid=1 and busy=1; outValid is first asserted the cycle after done.
REQ-018 Transfer shall occur on an edge where outValid && outReady; on transfer idx increments by 1.
REQ-019 Outputs shall hold stable while outValid && !outReady.
REQ-020 Transfer at idx == N-1 shall return the FSM to IDLE, with outValid=0 the next cycle unless REQ-021 applies.
REQ-021 If done=1 in the same cycle as the idx == N-1 transfer, the new frame shall be captured, idx=0, and the FSM shall stay in STREAM with no bubble.
REQ-022 If done=1 in STREAM at any other time, the pulse shall be ignored, the held frame left intact, and overrun set to 1.
REQ-023 outIdx equals idx; outLast = outValid && (idx == N-1).
REQ-024 Data path: no arithmetic or width change; components are passed bit-exact.
REQ-025 Throughput: one sample per cycle while outReady stays high; a frame takes N cycles after capture.

Reset
REQ-026 While rst=0, asynchronously: FSM=IDLE, idx=0, outValid=0, outLast=0, busy=0, overrun=0, and outRe/outIm/outIdx=0.
REQ-027 Reset asserted mid-frame shall discard the frame; the first sample after release comes only from a new done.
REQ-028 The frame buffer need not be reset.

Configuration
REQ-029 Macro FFT_BITREV_REORDER_EN.
REQ-030 When defined, the sample emitted at index idx is buffer[bitrev(idx)], which converts the fft's bit-reversed output into natural order.
REQ-031 When undefined, the sample emitted at index idx is buffer[idx].
REQ-032 In both builds, outIdx is always the natural idx.

Structure
REQ-033 Shared package fft_pkg: FFT_N=64, FFT_W=16, FFT_LOG2N=6, and the stream state enum typedef.
REQ-034 fft_pkg also holds the bitrev function of width FFT_LOG2N.
REQ-035 One sub-module, fft_sample_mux: combinational N:1 selection of a W-bit component by index; instanced once for Re and once for Im.

Verification
REQ-036 Frame with inRe samples 0..31 = 4 and 32..63 = 0, all Im = 0, outReady=1, no reorder -> outValid high the cycle after done; 64 consecutive samples: Re=4 for idx 0..31, Re=0 for idx 32..63; outLast only at idx 63; outValid low the next cycle.
REQ-037 Sample k has Re=k and Im=-k, FFT_BITREV_REORDER_EN defined -> sample at idx 1 is Re=32, Im=-32; idx 2 is Re=16; idx 63 is Re=63.
REQ-038 outReady toggles 1,0,0,1 repeatedly -> no sample lost or duplicated, outputs stable while stalled, 64 transfers total.
REQ-039 Second done at idx 10 -> overrun=1; stream continues with the original data through idx 63; second frame dropped.
REQ-040 Second done coincident with the idx 63 transfer -> next cycle idx=0 with the new frame data, outValid stays 1, overrun stays 0.
REQ-041 rst driven low at idx 20 -> outValid, busy and overrun drop to 0 immediately; no output until the next done.
